dp_sequencer: RTL and testbench
===============================

Name: dp_sequencer

Overview:
Command-driven controller that sequences the 32x32 register file and its adder datapath.
- Accepts one ALU command at a time over a valid/ready handshake.
- Drives the register file read selects, captures the operands, computes the result internally, then issues a single write-back strobe.
- Sits between the command source (test harness or wishbone shim) and the register file instance.

Parameters:
DATA_W, 32, datapath and register width
ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
i_CLK  input  1  clock, all logic on rising edge
i_RST  input  1  synchronous reset, active-high
i_CMD_VALID  input  1  command present
o_CMD_READY  output  1  sequencer can accept a command
i_CMD_OP  input  2  00 ADD, 01 SUB, 10 LDI, 11 MOV
i_CMD_RD  input  ADDR_W  destination register
i_CMD_RS0  input  ADDR_W  source operand A
i_CMD_RS1  input  ADDR_W  source operand B
i_CMD_IMM  input  DATA_W  immediate for LDI
o_R0  output  ADDR_W  register file read select 0
o_R1  output  ADDR_W  register file read select 1
i_Q0  input  DATA_W  register file read data 0 (combinational from o_R0)
i_Q1  input  DATA_W  register file read data 1 (combinational from o_R1)
o_WE  output  1  register file write enable
o_S  output  ADDR_W  register file write select
o_D  output  DATA_W  register file write data
o_DONE  output  1  one-cycle pulse, command retired
o_RESULT  output  DATA_W  last written value, held until next write

Behaviour:
- Clock and reset: one clock, i_CLK. Reset i_RST is synchronous and active-high.
- Reset values: state IDLE; o_CMD_READY=1; o_WE=0; o_DONE=0; o_S, o_D, o_R0, o_R1, o_RESULT=0; internal operand and command registers=0.
- State IDLE:
  - o_CMD_READY=1.
  - A command is accepted on a rising edge where i_CMD_VALID and o_CMD_READY are both 1. All i_CMD_* fields are latched on that edge.
  - LDI goes to WB. All other ops go to READ.
- State READ:
  - o_R0=latched RS0, o_R1=latched RS1.
  - i_Q0 and i_Q1 are captured into operand registers at the end of the cycle. Next state is EXEC.
- State EXEC:
  - ADD: A+B. SUB: A-B (two's complement). MOV: A.
  - Arithmetic is modulo 2^DATA_W; carry/borrow is discarded.
  - The result is registered. Next state is WB.
- State WB:
  - o_WE=1, o_S=latched RD, o_D=result (LDI: latched IMM).
  - o_RESULT is updated on the same edge as the write. o_DONE=1 for this cycle only.
  - Next state is IDLE.
- o_CMD_READY is 0 in READ, EXEC and WB. At most one command is in flight.
- Latency, with acceptance at edge N:
  - ADD/SUB/MOV: o_WE high in cycle N+3, o_CMD_READY high again in cycle N+4.
  - LDI: o_WE high in cycle N+1, o_CMD_READY high in cycle N+2.
- No read-after-write hazard: the write-back completes before the next command is accepted. A back-to-back command that reads the previous RD sees the new value.
- RD may equal RS0 or RS1. Operands are captured before the write, so the old value is used.
- All register indices are valid, including 0. Register 0 is not hardwired.
- o_R0/o_R1 hold their last value outside READ; they are don't-care to the register file.
- i_CMD_VALID deasserted in IDLE: no state change.
- i_CMD_VALID held high after acceptance: ignored until o_CMD_READY returns.
- Reset mid-operation: the command is aborted. No write occurs on or after the reset edge. Outputs return to reset values on the next edge.

Optional Feature:
SEQ_FLAGS_EN
- Defined:
  - Adds o_CARRY (1 bit) and o_ZERO (1 bit) outputs, both registered in EXEC and held until the next EXEC.
  - o_CARRY is the carry out of ADD, or the not-borrow (A>=B unsigned) of SUB. It is 0 for MOV.
  - o_ZERO=1 when the EXEC result is 0. LDI does not update either flag. Both reset to 0.
- Not defined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then LDI rd=3 imm=0x0000_0005 -> o_WE=1 one cycle after accept with o_S=3, o_D=5; o_DONE pulse; o_RESULT=5.
- LDI r1=0xFFFF_FFFF, LDI r2=1, ADD rd=4 rs0=1 rs1=2 -> o_D=0x0000_0000 at N+3. With SEQ_FLAGS_EN: o_CARRY=1, o_ZERO=1.
- r1=10, r2=3: SUB rd=5 rs0=2 rs1=1 -> o_D=0xFFFF_FFF9. With SEQ_FLAGS_EN: o_CARRY=0.
- ADD rd=1 rs0=1 rs1=1 with r1=7, then MOV rd=6 rs0=1 offered back-to-back -> o_D=14, then o_D=14 to r6. MOV accepted only when o_CMD_READY returns, 4 cycles after the ADD.
- i_CMD_VALID held high with a stream of 3 LDIs -> accepts exactly every 2 cycles; o_DONE count=3; no dropped or duplicated writes.
- Accept ADD, assert i_RST in EXEC -> o_WE never asserts, o_DONE stays 0, o_CMD_READY=1 the cycle after reset deasserts, o_RESULT=0.

Source files
------------

// File: rtl/dp_sequencer.sv
// Command sequencer for the register file + adder datapath: IDLE -> READ -> EXEC -> WB.
// Define SEQ_FLAGS_EN to add the o_CARRY/o_ZERO flag outputs.
module dp_sequencer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              i_CLK,
   input  logic              i_RST,
   input  logic              i_CMD_VALID,
   output logic              o_CMD_READY,
   input  logic [1:0]        i_CMD_OP,
   input  logic [ADDR_W-1:0] i_CMD_RD,
   input  logic [ADDR_W-1:0] i_CMD_RS0,
   input  logic [ADDR_W-1:0] i_CMD_RS1,
   input  logic [DATA_W-1:0] i_CMD_IMM,
   output logic [ADDR_W-1:0] o_R0,
   output logic [ADDR_W-1:0] o_R1,
   input  logic [DATA_W-1:0] i_Q0,
   input  logic [DATA_W-1:0] i_Q1,
   output logic              o_WE,
   output logic [ADDR_W-1:0] o_S,
   output logic [DATA_W-1:0] o_D,
   output logic              o_DONE,
`ifdef SEQ_FLAGS_EN
   output logic              o_CARRY,
   output logic              o_ZERO,
`endif
   output logic [DATA_W-1:0] o_RESULT
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_LDI = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   state_t              state;
   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   rd_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [DATA_W-1:0]   alu_res;

   // Modulo-2^DATA_W ALU on the captured operands; MOV passes A through.
   always_comb begin
      alu_res = a_q;
      case (op_q)
         OP_ADD:  alu_res = a_q + b_q;
         OP_SUB:  alu_res = a_q - b_q;
         default: alu_res = a_q;
      endcase
   end

`ifdef SEQ_FLAGS_EN
   logic alu_carry;

   // ADD overflowed iff the wrapped sum is below A; SUB reports not-borrow.
   always_comb begin
      alu_carry = 1'b0;
      if (op_q == OP_ADD) begin
         alu_carry = (alu_res < a_q);
      end else if (op_q == OP_SUB) begin
         alu_carry = (a_q >= b_q);
      end
   end
`endif

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state       <= ST_IDLE;
         o_CMD_READY <= 1'b1;
         o_WE        <= 1'b0;
         o_DONE      <= 1'b0;
         o_S         <= '0;
         o_D         <= '0;
         o_R0        <= '0;
         o_R1        <= '0;
         o_RESULT    <= '0;
         op_q        <= '0;
         rd_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
`ifdef SEQ_FLAGS_EN
         o_CARRY     <= 1'b0;
         o_ZERO      <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_CMD_VALID && o_CMD_READY) begin
                  o_CMD_READY <= 1'b0;
                  op_q        <= i_CMD_OP;
                  rd_q        <= i_CMD_RD;
                  if (i_CMD_OP == OP_LDI) begin
                     // Immediate needs no operands: go straight to write-back.
                     state  <= ST_WB;
                     o_WE   <= 1'b1;
                     o_DONE <= 1'b1;
                     o_S    <= i_CMD_RD;
                     o_D    <= i_CMD_IMM;
                  end else begin
                     state <= ST_READ;
                     o_R0  <= i_CMD_RS0;
                     o_R1  <= i_CMD_RS1;
                  end
               end
            end
            ST_READ: begin
               a_q   <= i_Q0;
               b_q   <= i_Q1;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               o_WE   <= 1'b1;
               o_DONE <= 1'b1;
               o_S    <= rd_q;
               o_D    <= alu_res;
`ifdef SEQ_FLAGS_EN
               o_CARRY <= alu_carry;
               o_ZERO  <= (alu_res == '0);
`endif
               state  <= ST_WB;
            end
            ST_WB: begin
               o_WE        <= 1'b0;
               o_DONE      <= 1'b0;
               o_RESULT    <= o_D;
               o_CMD_READY <= 1'b1;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer with a behavioural 32x32 register file attached.
module tb_dp_sequencer;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_LDI = 2'b10;
   localparam logic [1:0] OP_MOV = 2'b11;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = '0;
   logic [ADDR_W-1:0] cmd_rd = '0;
   logic [ADDR_W-1:0] cmd_rs0 = '0;
   logic [ADDR_W-1:0] cmd_rs1 = '0;
   logic [DATA_W-1:0] cmd_imm = '0;
   logic [ADDR_W-1:0] r0, r1, s;
   logic [DATA_W-1:0] q0, q1, d, result;
   logic              we, done;
`ifdef SEQ_FLAGS_EN
   logic              carry, zero;
`endif

   logic [DATA_W-1:0] rf [32] = '{default: '0};
   int done_cnt = 0;
   int we_cnt   = 0;
   int passed   = 0;
   int total    = 0;
   int base;

   dp_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .i_CLK(clk), .i_RST(rst),
      .i_CMD_VALID(cmd_valid), .o_CMD_READY(cmd_ready),
      .i_CMD_OP(cmd_op), .i_CMD_RD(cmd_rd), .i_CMD_RS0(cmd_rs0),
      .i_CMD_RS1(cmd_rs1), .i_CMD_IMM(cmd_imm),
      .o_R0(r0), .o_R1(r1), .i_Q0(q0), .i_Q1(q1),
      .o_WE(we), .o_S(s), .o_D(d), .o_DONE(done),
`ifdef SEQ_FLAGS_EN
      .o_CARRY(carry), .o_ZERO(zero),
`endif
      .o_RESULT(result)
   );

   always #5 clk = ~clk;

   assign q0 = rf[r0];
   assign q1 = rf[r1];

   always @(posedge clk) begin
      if (we) rf[s] <= d;
      if (done) done_cnt++;
      if (we) we_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one command, wait (bounded) for the write strobe, check it and the retire cycle.
   task automatic do_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs0,
                         input logic [4:0] rs1, input logic [31:0] imm,
                         input logic [31:0] exp_d, input int exp_lat, input string tag);
      int lat;
      cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs0 = rs0; cmd_rs1 = rs1; cmd_imm = imm;
      step();
      cmd_valid = 1'b0;
      lat = 1;
      while (!we && lat < 8) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_s"}, 32'(s), 32'(rd));
      chk({tag, "_d"}, d, exp_d);
      chk({tag, "_done"}, 32'(done), 32'd1);
      step();
      chk({tag, "_result"}, result, exp_d);
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_we_low"}, 32'(we), 32'd0);
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_d", d, 32'd0);
      chk("rst_r0", 32'(r0), 32'd0);
      rst = 1'b0;
      step();
      chk("idle_no_valid_ready", 32'(cmd_ready), 32'd1);

      do_cmd(OP_LDI, 5'd3, 5'd0, 5'd0, 32'h0000_0005, 32'h0000_0005, 1, "ldi_r3");
      chk("rf3", rf[3], 32'd5);

      // Wrapping add
      do_cmd(OP_LDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "ldi_r1");
      do_cmd(OP_LDI, 5'd2, 5'd0, 5'd0, 32'h0000_0001, 32'h0000_0001, 1, "ldi_r2");
      do_cmd(OP_ADD, 5'd4, 5'd1, 5'd2, 32'h0, 32'h0000_0000, 3, "add_wrap");
`ifdef SEQ_FLAGS_EN
      chk("add_wrap_carry", 32'(carry), 32'd1);
      chk("add_wrap_zero", 32'(zero), 32'd1);
`endif
      chk("rf4", rf[4], 32'd0);

      // Negative subtract
      do_cmd(OP_LDI, 5'd1, 5'd0, 5'd0, 32'd10, 32'd10, 1, "ldi_r1_10");
      do_cmd(OP_LDI, 5'd2, 5'd0, 5'd0, 32'd3, 32'd3, 1, "ldi_r2_3");
`ifdef SEQ_FLAGS_EN
      chk("ldi_keeps_carry", 32'(carry), 32'd1);
`endif
      do_cmd(OP_SUB, 5'd5, 5'd2, 5'd1, 32'h0, 32'hFFFF_FFF9, 3, "sub_neg");
`ifdef SEQ_FLAGS_EN
      chk("sub_neg_carry", 32'(carry), 32'd0);
      chk("sub_neg_zero", 32'(zero), 32'd0);
`endif

      // ADD r1=r1+r1 then MOV r6=r1 offered back-to-back
      do_cmd(OP_LDI, 5'd1, 5'd0, 5'd0, 32'd7, 32'd7, 1, "ldi_r1_7");
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 5'd1; cmd_rs0 = 5'd1; cmd_rs1 = 5'd1;
      step();
      chk("b2b_busy", 32'(cmd_ready), 32'd0);
      chk("b2b_r0", 32'(r0), 32'd1);
      cmd_op = OP_MOV; cmd_rd = 5'd6; cmd_rs0 = 5'd1; cmd_rs1 = 5'd0;
      step();
      chk("b2b_exec_busy", 32'(cmd_ready), 32'd0);
      step();
      chk("b2b_add_we", 32'(we), 32'd1);
      chk("b2b_add_d", d, 32'd14);
      chk("b2b_add_s", 32'(s), 32'd1);
      step();
      chk("b2b_ready_back", 32'(cmd_ready), 32'd1);
      chk("b2b_add_result", result, 32'd14);
      step();
      chk("b2b_mov_accepted", 32'(cmd_ready), 32'd0);
      chk("b2b_mov_r0", 32'(r0), 32'd1);
      cmd_valid = 1'b0;
      step();
      step();
      chk("b2b_mov_we", 32'(we), 32'd1);
      chk("b2b_mov_d", d, 32'd14);
      chk("b2b_mov_s", 32'(s), 32'd6);
`ifdef SEQ_FLAGS_EN
      chk("mov_carry", 32'(carry), 32'd0);
      chk("mov_zero", 32'(zero), 32'd0);
`endif
      step();
      chk("rf6", rf[6], 32'd14);
      chk("rf1", rf[1], 32'd14);

      // Stream of LDIs with valid held high
      base = done_cnt;
      cmd_valid = 1'b1; cmd_op = OP_LDI;
      for (int i = 0; i < 3; i++) begin
         cmd_rd = 5'(7 + i);
         cmd_imm = 32'hA0 + 32'(i);
         step();
         chk("stream_we", 32'(we), 32'd1);
         chk("stream_d", d, 32'hA0 + 32'(i));
         chk("stream_s", 32'(s), 32'(7 + i));
         if (i == 2) cmd_valid = 1'b0;
         step();
         chk("stream_gap_we", 32'(we), 32'd0);
         chk("stream_gap_ready", 32'(cmd_ready), 32'd1);
      end
      step();
      chk("stream_no_extra", 32'(we), 32'd0);
      chk("stream_done_cnt", 32'(done_cnt - base), 32'd3);
      chk("stream_rf7", rf[7], 32'hA0);
      chk("stream_rf8", rf[8], 32'hA1);
      chk("stream_rf9", rf[9], 32'hA2);

      // Reset while the ADD is in EXEC
      base = we_cnt;
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 5'd10; cmd_rs0 = 5'd1; cmd_rs1 = 5'd2;
      step();
      cmd_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_we", 32'(we), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      chk("abort_result", result, 32'd0);
      step();
      step();
      chk("abort_we_later", 32'(we), 32'd0);
      chk("abort_ready_later", 32'(cmd_ready), 32'd1);
      chk("abort_we_cnt", 32'(we_cnt - base), 32'd0);
      chk("abort_rf10", rf[10], 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
